apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum number of ACCESS cycles before abort (used only with APB_MASTER_TIMEOUT_EN).
REQ-004 SHALL have port PCLK  input  1  APB clock; all logic on rising edge.
REQ-005 SHALL have port PRESETN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid  input  1, req_ready  output  1: request handshake.
REQ-007 SHALL have ports req_addr  input  ADDR_W, req_write  input  1, req_wdata  input  DATA_W: request payload.
REQ-008 SHALL have ports rsp_valid  output  1 (one-cycle pulse), rsp_rdata  output  DATA_W, rsp_err  output  1, rsp_timeout  output  1.
REQ-009 SHALL have APB outputs PADDR ADDR_W, PSEL 1, PENABLE 1, PWRITE 1, PWDATA DATA_W.
REQ-010 SHALL have APB inputs PRDATA DATA_W, PREADY 1, PSLVERR 1.

Function
REQ-011 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready.
REQ-013 On acceptance, the block SHALL latch addr, write and wdata into PADDR, PWRITE and PWDATA, and go to SETUP on the next edge.
REQ-014 In SETUP, outputs SHALL be PSEL=1 and PENABLE=0; the FSM SHALL go unconditionally to ACCESS after one cycle.
REQ-015 In ACCESS, outputs SHALL be PSEL=1 and PENABLE=1; the FSM SHALL stay in ACCESS while PREADY=0.
REQ-016 In ACCESS with PREADY=1, the block SHALL register PRDATA (reads) or zero (writes) into rsp_rdata and PSLVERR into rsp_err, pulse rsp_valid for exactly one cycle on the next cycle, and return to IDLE.
REQ-017 Zero-wait latency SHALL be: accept at cycle T, SETUP at T+1, ACCESS at T+2, rsp_valid and req_ready at T+3.
REQ-018 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the end of ACCESS, and hold their last values in IDLE.
REQ-019 PSEL SHALL be low for at least one cycle (IDLE) between consecutive transfers; back-to-back throughput SHALL be one transfer per 3 cycles minimum.
REQ-020 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next response; they are valid only while rsp_valid=1.
REQ-021 req_* inputs SHALL be ignored outside IDLE; a req_valid held high SHALL be accepted in the IDLE cycle that follows rsp_valid.
REQ-022 PRDATA and PSLVERR SHALL be ignored when PREADY=0.

Reset
REQ-023 Asserting PRESETN low SHALL force IDLE asynchronously, with PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and rsp_timeout all 0 and req_ready 1 after release.
REQ-024 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid generated.

Configuration
REQ-025 With macro APB_MASTER_TIMEOUT_EN defined, an ACCESS-cycle counter SHALL start at 1 on ACCESS entry; if PREADY=0 when the count equals TIMEOUT_CYCLES, the block SHALL drop PSEL and PENABLE, return to IDLE, and pulse rsp_valid next cycle with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-026 With APB_MASTER_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely for PREADY, rsp_timeout SHALL be tied to 0, and no counter logic SHALL exist.
REQ-027 PREADY=1 in the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally, with no timeout.

Structure
REQ-028 The FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and the TIMEOUT_CYCLES default SHALL live in shared package apb_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and inline.

Verification
REQ-030 Write with zero wait: addr=5'h08, wdata=8'h5A, PREADY=1 -> PSEL high at T+1 and T+2, PENABLE high only at T+2, PADDR=5'h08 and PWDATA=8'h5A stable, rsp_valid at T+3 with rsp_err=0.
REQ-031 Read with 3 wait states: addr=5'h04, slave returns PRDATA=8'hA5 with PREADY on the 4th ACCESS cycle -> rsp_rdata=8'hA5, rsp_valid exactly one cycle, PENABLE high for 4 cycles.
REQ-032 Slave error: PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0; PSLVERR=1 with PREADY=0 is ignored.
REQ-033 Back-to-back: req_valid held high for two requests -> second PSEL rise exactly 3 cycles after the first, with PSEL low for one cycle between.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=16): PREADY held 0 -> PSEL drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=8'h00; with macro off, the transfer still waits at cycle 100.
REQ-035 Reset mid-ACCESS: PRESETN low while PREADY=0 -> PSEL and PENABLE go to 0 immediately, no rsp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and default timeout length.
package apb_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// Single-transfer APB master: request handshake in IDLE, SETUP/ACCESS phases, registered response pulse.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t        r_state;
    apb_state_t        w_state_next;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: w_state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_timeout;

    // Counter reads 1 in the first ACCESS cycle, so it equals the ACCESS cycle number.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_cnt <= CNT_W'(1);
        end else if (r_state == ST_ACCESS && !PREADY && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_ACCESS) && !PREADY && (r_cnt == CNT_MAX);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_timeout <= 1'b1;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done | w_timeout;
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                r_rsp_err   <= PSLVERR;
            end else if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign PSEL      = (r_state != ST_IDLE);
    assign PENABLE   = (r_state == ST_ACCESS);
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: timestamp-based transfer model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_apb_master;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int TO     = 16;

    logic              PCLK;
    logic              PRESETN;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_master #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a transfer is described by its accept cycle; all outputs
    // follow from the offset of the current cycle from that accept cycle.
    initial begin
        int cyc = 0;
        bit busy = 0;
        int t_acc = 0;
        int d;
        bit nrv;
        logic              e_ready = 1'b1, e_psel = 1'b0, e_pen = 1'b0, e_pwrite = 1'b0;
        logic              e_rv = 1'b0, e_err = 1'b0, e_to = 1'b0;
        logic [ADDR_W-1:0] e_paddr = '0;
        logic [DATA_W-1:0] e_pwdata = '0, e_rdata = '0;
        forever begin
            @(negedge PCLK);
            cyc++;
            if (!PRESETN) begin
                busy = 0; e_ready = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_pwrite = 1'b0;
                e_rv = 1'b0; e_err = 1'b0; e_to = 1'b0; e_paddr = '0; e_pwdata = '0; e_rdata = '0;
            end
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("PSEL", 32'(PSEL), 32'(e_psel));
            check("PENABLE", 32'(PENABLE), 32'(e_pen));
            check("PADDR", 32'(PADDR), 32'(e_paddr));
            check("PWRITE", 32'(PWRITE), 32'(e_pwrite));
            check("PWDATA", 32'(PWDATA), 32'(e_pwdata));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
            check("rsp_err", 32'(rsp_err), 32'(e_err));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
            if (PRESETN) begin
                nrv = 0;
                if (!busy) begin
                    if (req_valid) begin
                        busy = 1; t_acc = cyc;
                        e_paddr = req_addr; e_pwrite = req_write; e_pwdata = req_wdata;
                    end
                end else begin
                    d = cyc - t_acc;
                    if (d >= 2) begin
                        if (PREADY) begin
                            busy = 0; nrv = 1;
                            e_rdata = e_pwrite ? '0 : PRDATA;
                            e_err = PSLVERR; e_to = 1'b0;
                        end
`ifdef APB_MASTER_TIMEOUT_EN
                        else if (d - 1 == TO) begin
                            busy = 0; nrv = 1;
                            e_rdata = '0; e_err = 1'b1; e_to = 1'b1;
                        end
`endif
                    end
                end
                e_ready = !busy;
                e_psel  = busy;
                e_pen   = busy && (cyc + 1 - t_acc >= 2);
                e_rv    = nrv;
            end
        end
    end

    // Drive inputs for the cycle that begins at the next rising edge.
    task automatic drive(input bit rv, input logic [ADDR_W-1:0] a, input bit w,
                         input logic [DATA_W-1:0] wd, input bit rdy,
                         input logic [DATA_W-1:0] prd, input bit serr);
        @(posedge PCLK);
        #2;
        req_valid = rv; req_addr = a; req_write = w; req_wdata = wd;
        PREADY = rdy; PRDATA = prd; PSLVERR = serr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, '0, 0, '0, 0);
    endtask

    initial begin
        int pen_cnt;
        int rv_cnt;
        int rise0;
        int rise1;
        int nrise;
        bit prev_psel;
        PRESETN = 1'b0; req_valid = 0; req_addr = '0; req_write = 0; req_wdata = '0;
        PREADY = 0; PRDATA = '0; PSLVERR = 0;
        @(negedge PCLK);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_psel", 32'(PSEL), 32'd0);
        idle(2);
        PRESETN = 1'b1;
        idle(2);

        // Zero-wait write
        drive(1, 5'h08, 1, 8'h5A, 1, 8'h00, 0);
        drive(0, 5'h1F, 0, 8'hFF, 1, 8'h00, 0);
        @(negedge PCLK);
        check("wr_T1_psel", 32'(PSEL), 32'd1);
        check("wr_T1_pen", 32'(PENABLE), 32'd0);
        check("wr_T1_paddr", 32'(PADDR), 32'h08);
        drive(0, '0, 0, '0, 1, 8'h00, 0);
        @(negedge PCLK);
        check("wr_T2_pen", 32'(PENABLE), 32'd1);
        check("wr_T2_pwdata", 32'(PWDATA), 32'h5A);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        @(negedge PCLK);
        check("wr_T3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_T3_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_T3_ready", 32'(req_ready), 32'd1);
        idle(2);

        // Read with 3 wait states, PSLVERR noise while not ready
        drive(1, 5'h04, 0, 8'h00, 0, 8'h11, 1);
        pen_cnt = 0; rv_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) drive(0, '0, 0, '0, 1, 8'hA5, 0);
            else        drive(0, '0, 0, '0, 0, 8'h3C, 1);
            @(negedge PCLK);
            if (PENABLE) pen_cnt++;
            if (rsp_valid) begin
                rv_cnt++;
                check("rd_rdata", 32'(rsp_rdata), 32'hA5);
                check("rd_err", 32'(rsp_err), 32'd0);
            end
        end
        check("rd_penable_cycles", 32'(pen_cnt), 32'd4);
        check("rd_rsp_pulses", 32'(rv_cnt), 32'd1);

        // Slave error on completion
        drive(1, 5'h02, 1, 8'h77, 1, 8'h00, 1);
        drive(0, '0, 0, '0, 1, 8'h00, 1);
        drive(0, '0, 0, '0, 1, 8'h00, 1);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        @(negedge PCLK);
        check("err_rsp_valid", 32'(rsp_valid), 32'd1);
        check("err_rsp_err", 32'(rsp_err), 32'd1);
        check("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
        idle(2);

        // Back-to-back with req_valid held high
        rise0 = 0; rise1 = 0; nrise = 0; prev_psel = 0;
        for (int k = 0; k < 8; k++) begin
            drive(k < 4, 5'h10, 0, 8'h00, 1, 8'h5C, 0);
            @(negedge PCLK);
            if (PSEL && !prev_psel) begin
                if (nrise == 0) rise0 = k; else if (nrise == 1) rise1 = k;
                nrise++;
            end
            prev_psel = PSEL;
        end
        check("b2b_rise_gap", 32'(rise1 - rise0), 32'd3);
        idle(2);

`ifdef APB_MASTER_TIMEOUT_EN
        drive(1, 5'h01, 0, 8'h00, 0, 8'hEE, 0);
        pen_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            drive(0, '0, 0, '0, 0, 8'hEE, 0);
            @(negedge PCLK);
            if (PENABLE) pen_cnt++;
            if (!PSEL) break;
        end
        check("to_penable_cycles", 32'(pen_cnt), 32'd16);
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        check("to_rsp_rdata", 32'(rsp_rdata), 32'h00);
`else
        drive(1, 5'h01, 0, 8'h00, 0, 8'hEE, 0);
        for (int k = 0; k < 100; k++) drive(0, '0, 0, '0, 0, 8'hEE, 0);
        @(negedge PCLK);
        check("nto_still_psel", 32'(PSEL), 32'd1);
        check("nto_still_pen", 32'(PENABLE), 32'd1);
        drive(0, '0, 0, '0, 1, 8'h42, 0);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        @(negedge PCLK);
        check("nto_rsp_rdata", 32'(rsp_rdata), 32'h42);
`endif
        idle(2);

        // Reset in the middle of ACCESS
        drive(1, 5'h06, 0, 8'h00, 0, 8'h00, 0);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        PRESETN = 1'b0;
        #1;
        check("rst_psel_immediate", 32'(PSEL), 32'd0);
        check("rst_pen_immediate", 32'(PENABLE), 32'd0);
        idle(2);
        PRESETN = 1'b1;
        rv_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            @(negedge PCLK);
            if (rsp_valid) rv_cnt++;
            check("rst_ready_after", 32'(req_ready), 32'd1);
        end
        check("rst_no_rsp", 32'(rv_cnt), 32'd0);

        // Randomized traffic; the model checks every cycle
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 1) == 1, ADDR_W'($urandom), $urandom_range(0, 1) == 1,
                  DATA_W'($urandom), $urandom_range(0, 2) != 0, DATA_W'($urandom),
                  $urandom_range(0, 3) == 0);
        end
        idle(40);
        @(negedge PCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
